// File: rtl/pdm_rx_if.sv
// Read-side bus of the PDM receiver: pop/clear strobes from the consumer,
// current sample, valid and sticky overrun flags from the receiver.
interface pdm_rx_if;
    logic       re;
    logic       ovr_clr;
    logic [7:0] pcm_o;
    logic       valid_o;
    logic       overrun_o;

    modport master (
        output re,
        output ovr_clr,
        input  pcm_o,
        input  valid_o,
        input  overrun_o
    );

    modport slave (
        input  re,
        input  ovr_clr,
        output pcm_o,
        output valid_o,
        output overrun_o
    );
endinterface

// File: rtl/pdm_rx.sv
// 1-bit PDM microphone receiver: bit-clock divider, 2-flop input sync, boxcar
// decimation to 8-bit PCM. Define PDM_RX_FIFO_EN for a 4-deep output FIFO.
module pdm_rx #(
    parameter int CLK_DIV = 16,
    parameter int DECIM   = 256
) (
    input  logic     clk,
    input  logic     resetn,
    input  logic     en,
    output logic     pdm_clk_o,
    input  logic     pdm_i,
    pdm_rx_if.slave  bus
);

    localparam int L     = $clog2(DECIM);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int SHIFT = 8 - L;

    logic sync1_reg, sync2_reg;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= pdm_i;
            sync2_reg <= sync1_reg;
        end
    end

    // Bit-clock divider; pdm_clk_o is registered from the next count so it
    // stays aligned with div_cnt_reg.
    logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
    logic             pdm_clk_reg;
    logic             tick;

    assign tick = en && (div_cnt_reg == DIV_W'(CLK_DIV - 1));

    always_comb begin
        div_cnt_next = '0;
        if (en && !tick)
            div_cnt_next = div_cnt_reg + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            div_cnt_reg <= '0;
            pdm_clk_reg <= 1'b0;
        end else begin
            div_cnt_reg <= div_cnt_next;
            pdm_clk_reg <= en && (div_cnt_next >= DIV_W'(CLK_DIV / 2));
        end
    end

    assign pdm_clk_o = pdm_clk_reg;

    logic [L-1:0] bit_cnt_reg;
    logic [L:0]   ones_cnt_reg, ones_sum;
    logic         frame_end;
    logic [8:0]   pcm_wide;
    logic [7:0]   sample;

    assign ones_sum  = ones_cnt_reg + (L+1)'(sync2_reg);
    assign frame_end = tick && (bit_cnt_reg == L'(DECIM - 1));
    assign pcm_wide  = 9'(ones_sum) << SHIFT;
    // Only a frame of all ones reaches 256; clamp it to full scale.
    assign sample    = pcm_wide[8] ? 8'hFF : pcm_wide[7:0];

    always_ff @(posedge clk) begin
        if (!resetn || !en) begin
            bit_cnt_reg  <= '0;
            ones_cnt_reg <= '0;
        end else if (tick) begin
            if (frame_end) begin
                bit_cnt_reg  <= '0;
                ones_cnt_reg <= '0;
            end else begin
                bit_cnt_reg  <= bit_cnt_reg + 1'b1;
                ones_cnt_reg <= ones_sum;
            end
        end
    end

    logic drop;
    logic overrun_reg;

`ifdef PDM_RX_FIFO_EN
    logic [7:0] fifo_mem [4];
    logic [1:0] wr_ptr_reg, rd_ptr_reg;
    logic [2:0] count_reg;
    logic       pop, push;

    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign pop  = bus.re && (count_reg != 3'd0);
    assign push = frame_end && ((count_reg != 3'd4) || pop);
    assign drop = frame_end && !push;

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= sample;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign bus.pcm_o   = (count_reg != 3'd0) ? fifo_mem[rd_ptr_reg] : 8'd0;
    assign bus.valid_o = (count_reg != 3'd0);
`else
    logic [7:0] pcm_reg;
    logic       valid_reg;

    assign drop = frame_end && valid_reg && !bus.re;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pcm_reg   <= '0;
            valid_reg <= 1'b0;
        end else if (frame_end && (!valid_reg || bus.re)) begin
            pcm_reg   <= sample;
            valid_reg <= 1'b1;
        end else if (bus.re && valid_reg) begin
            valid_reg <= 1'b0;
        end
    end

    assign bus.pcm_o   = pcm_reg;
    assign bus.valid_o = valid_reg;
`endif

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk) begin
        if (!resetn)
            overrun_reg <= 1'b0;
        else if (drop)
            overrun_reg <= 1'b1;
        else if (bus.ovr_clr)
            overrun_reg <= 1'b0;
    end

    assign bus.overrun_o = overrun_reg;

endmodule

// File: tb/tb_pdm_rx.sv
// Directed + random bench for pdm_rx; expected samples come from a ones-count
// model and a bounded queue standing in for the output buffer.
module tb_pdm_rx;

    localparam int CLK_DIV = 4;
    localparam int DECIM   = 16;
`ifdef PDM_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic en = 1'b0;
    logic pdm_i = 1'b0;
    logic pdm_clk_o;

    pdm_rx_if bus ();

    pdm_rx #(.CLK_DIV(CLK_DIV), .DECIM(DECIM)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .en        (en),
        .pdm_clk_o (pdm_clk_o),
        .pdm_i     (pdm_i),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int mq[$];
    bit movr = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int pcm_of(input int n);
        int v;
        v = n * (256 / DECIM);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_valid"}, 32'(bus.valid_o), 32'(mq.size() > 0));
        check({tag, "_ovr"}, 32'(bus.overrun_o), 32'(movr));
        if (mq.size() > 0)
            check({tag, "_pcm"}, 32'(bus.pcm_o), 32'(mq[0]));
    endtask

    // One PDM bit period, starting and ending at a negedge where div_cnt is 0.
    task automatic pdm_bit(input bit b, input bit re_end, input bit chk_clk);
        pdm_i = b;
        for (int i = 1; i <= CLK_DIV; i++) begin
            if (i == CLK_DIV && re_end)
                bus.re = 1'b1;
            @(negedge clk);
            bus.re = 1'b0;
            if (chk_clk)
                check("pdm_clk", 32'(pdm_clk_o), 32'((i % CLK_DIV) >= CLK_DIV / 2));
        end
    endtask

    task automatic run_frame(input logic [DECIM-1:0] bits, input bit re_end,
                             input bit chk_clk, input string tag);
        int n;
        n = 0;
        for (int k = 0; k < DECIM; k++) begin
            pdm_bit(bits[k], re_end && (k == DECIM - 1), chk_clk);
            n += int'(bits[k]);
        end
        if (re_end && mq.size() > 0)
            void'(mq.pop_front());
        if (mq.size() < DEPTH)
            mq.push_back(pcm_of(n));
        else
            movr = 1'b1;
        $display("frame %s: ones=%0d re=%0d pcm_o=%0d valid_o=%0d overrun_o=%0d",
                 tag, n, re_end, bus.pcm_o, bus.valid_o, bus.overrun_o);
        check_outputs(tag);
    endtask

    // Standalone strobes run with en low for one cycle so the bit phase is kept.
    task automatic pop(input string tag);
        en = 1'b0;
        bus.re = 1'b1;
        @(negedge clk);
        bus.re = 1'b0;
        en = 1'b1;
        if (mq.size() > 0)
            void'(mq.pop_front());
        $display("pop %s: pcm_o=%0d valid_o=%0d", tag, bus.pcm_o, bus.valid_o);
        check_outputs(tag);
    endtask

    task automatic clr(input string tag);
        en = 1'b0;
        bus.ovr_clr = 1'b1;
        @(negedge clk);
        bus.ovr_clr = 1'b0;
        en = 1'b1;
        movr = 1'b0;
        $display("clr %s: overrun_o=%0d", tag, bus.overrun_o);
        check_outputs(tag);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++)
            pop("drain");
    endtask

    initial begin
        logic [31:0] rnd;
        bus.re = 1'b0;
        bus.ovr_clr = 1'b0;

        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pdm_clk", 32'(pdm_clk_o), 32'd0);
        check("rst_pcm", 32'(bus.pcm_o), 32'd0);
        check("rst_valid", 32'(bus.valid_o), 32'd0);
        check("rst_ovr", 32'(bus.overrun_o), 32'd0);

        resetn = 1'b1;
        en = 1'b1;
        run_frame('1, 1'b0, 1'b1, "full");
        pop("pop_full");
        run_frame('0, 1'b0, 1'b0, "zero");
        pop("pop_zero");
        run_frame(16'h5555, 1'b0, 1'b0, "alt");
        pop("pop_alt");
        run_frame(16'h0007, 1'b0, 1'b0, "three");
        pop("pop_three");

        run_frame(16'h5555, 1'b0, 1'b0, "ovr_a");
        run_frame(16'h0000, 1'b0, 1'b0, "ovr_b");
        clr("ovr_clr");
        run_frame(16'h000F, 1'b1, 1'b0, "coinc");
        drain();
        clr("clr0");

        for (int r = 0; r < 10; r++) begin
            rnd = $urandom;
            run_frame(rnd[DECIM-1:0], 1'($urandom_range(0, 1)), 1'b0, "rand");
            if ($urandom_range(0, 1) == 1)
                pop("rand_pop");
            if ($urandom_range(0, 3) == 0)
                clr("rand_clr");
        end
        drain();
        clr("clr1");

        // Reset in the middle of a frame with an unread sample pending.
        run_frame('1, 1'b0, 1'b0, "pre_rst");
        for (int k = 0; k < 7; k++)
            pdm_bit(1'b1, 1'b0, 1'b0);
        resetn = 1'b0;
        @(negedge clk);
        check("mid_rst_pdm_clk", 32'(pdm_clk_o), 32'd0);
        check("mid_rst_pcm", 32'(bus.pcm_o), 32'd0);
        check("mid_rst_valid", 32'(bus.valid_o), 32'd0);
        check("mid_rst_ovr", 32'(bus.overrun_o), 32'd0);
        mq.delete();
        movr = 1'b0;
        resetn = 1'b1;
        run_frame('0, 1'b0, 1'b0, "rst_zero");
        pop("pop_rst_zero");
        run_frame('1, 1'b0, 1'b0, "rst_full");

        // Disable partway through a bit period while the bit clock is high.
        for (int k = 0; k < 5; k++)
            pdm_bit(1'b1, 1'b0, 1'b0);
        pdm_i = 1'b1;
        repeat (2) @(negedge clk);
        check("en_pre_pdm_clk", 32'(pdm_clk_o), 32'd1);
        en = 1'b0;
        @(negedge clk);
        check("en_off_pdm_clk", 32'(pdm_clk_o), 32'd0);
        check_outputs("en_hold");
        bus.re = 1'b1;
        @(negedge clk);
        bus.re = 1'b0;
        if (mq.size() > 0)
            void'(mq.pop_front());
        check_outputs("en_off_pop");
        en = 1'b1;
        run_frame('0, 1'b0, 1'b0, "en_fresh");
        drain();
        clr("clr2");

        // Five unread frames: 16, 32, 48, 64, 80.
        for (int i = 1; i <= 5; i++)
            run_frame(16'((1 << i) - 1), 1'b0, 1'b0, "fill");
        for (int i = 0; i < 4; i++)
            pop("fill_pop");
        check("fill_empty", 32'(bus.valid_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
